// File: rtl/r4w_nco_hop_sched.sv
// Frequency-hop scheduler: steps the NCO through a table of (freq, phase, dwell)
// entries, counting each dwell in NCO sample ticks.
module r4w_nco_hop_sched #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_we,
  input  logic [ADDR_W-1:0]  tbl_addr,
  input  logic [31:0]        tbl_freq,
  input  logic [31:0]        tbl_phase,
  input  logic [DWELL_W-1:0] tbl_dwell,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [ADDR_W:0]    num_hops,
  input  logic               sample_tick,
  output logic [31:0]        nco_freq,
  output logic [31:0]        nco_phase,
  output logic               nco_enable,
  output logic               nco_phase_rst,
  output logic               hop_strobe,
  output logic [ADDR_W-1:0]  hop_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned ENTRY_W = 64 + DWELL_W;
  localparam int unsigned NH_W    = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   rd_q;
  logic [ADDR_W-1:0]    idx_q;
  logic [NH_W-1:0]      nh_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic                 pend_q;
  logic [31:0]          freq_q;
  logic [31:0]          phase_q;
  logic                 enable_q;
  logic                 phase_rst_q;
  logic                 hop_strobe_q;
  logic [ADDR_W-1:0]    hop_idx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic                 nh_ok;
  logic                 is_last;
  logic [DWELL_W-1:0]   dwell_eff;

  // Table RAM: read-first on a same-address write, contents never reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      mem[tbl_addr] <= {tbl_freq, tbl_phase, tbl_dwell};
    end
    if (state_q == S_LOAD) begin
      rd_q <= mem[idx_q];
    end
  end

  always_comb begin
    nh_ok     = (num_hops != '0) && (num_hops <= NH_W'(DEPTH));
    is_last   = ({1'b0, idx_q} == (nh_q - NH_W'(1)));
    dwell_eff = (rd_q[DWELL_W-1:0] == '0) ? DWELL_W'(1) : rd_q[DWELL_W-1:0];
  end

  // The read data lands one cycle after LOAD, so the first DWELL cycle (pend_q)
  // applies the entry and ignores ticks; this gives the 2-cycle hop gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      nh_q         <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      freq_q       <= '0;
      phase_q      <= '0;
      enable_q     <= 1'b0;
      phase_rst_q  <= 1'b0;
      hop_strobe_q <= 1'b0;
      hop_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      phase_rst_q  <= 1'b0;
      hop_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      if (stop && (state_q != S_IDLE)) begin
        state_q  <= S_IDLE;
        enable_q <= 1'b0;
        busy_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (nh_ok) begin
                nh_q    <= num_hops;
                idx_q   <= '0;
                state_q <= S_LOAD;
                busy_q  <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            state_q <= S_DWELL;
            pend_q  <= 1'b1;
          end
          S_DWELL: begin
            if (pend_q) begin
              pend_q       <= 1'b0;
              freq_q       <= rd_q[ENTRY_W-1 -: 32];
              phase_q      <= rd_q[DWELL_W+31 : DWELL_W];
              hop_idx_q    <= idx_q;
              enable_q     <= 1'b1;
              phase_rst_q  <= 1'b1;
              hop_strobe_q <= 1'b1;
              cnt_q        <= dwell_eff;
            end else if (sample_tick) begin
              cnt_q <= cnt_q - DWELL_W'(1);
              if (cnt_q == DWELL_W'(1)) begin
                if (!is_last) begin
                  idx_q   <= idx_q + ADDR_W'(1);
                  state_q <= S_LOAD;
                end else if (loop_en) begin
                  idx_q   <= '0;
                  state_q <= S_LOAD;
                end else begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  enable_q <= 1'b0;
                end
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign nco_freq      = freq_q;
  assign nco_phase     = phase_q;
  assign nco_enable    = enable_q;
  assign nco_phase_rst = phase_rst_q;
  assign hop_strobe    = hop_strobe_q;
  assign hop_idx       = hop_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_r4w_nco_hop_sched.sv
// Scoreboard bench for r4w_nco_hop_sched: expected entries are queued at start
// and popped on each hop_strobe, with dwell measured in sampled ticks.
module tb_r4w_nco_hop_sched;

  logic        clk;
  logic        rst;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [31:0] tbl_freq;
  logic [31:0] tbl_phase;
  logic [15:0] tbl_dwell;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [4:0]  num_hops;
  logic        sample_tick;
  logic [31:0] nco_freq;
  logic [31:0] nco_phase;
  logic        nco_enable;
  logic        nco_phase_rst;
  logic        hop_strobe;
  logic [3:0]  hop_idx;
  logic        busy;
  logic        done;
  logic        err;

  r4w_nco_hop_sched #(.DEPTH(16), .ADDR_W(4), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_freq(tbl_freq), .tbl_phase(tbl_phase), .tbl_dwell(tbl_dwell),
    .start(start), .stop(stop), .loop_en(loop_en), .num_hops(num_hops),
    .sample_tick(sample_tick), .nco_freq(nco_freq), .nco_phase(nco_phase),
    .nco_enable(nco_enable), .nco_phase_rst(nco_phase_rst),
    .hop_strobe(hop_strobe), .hop_idx(hop_idx), .busy(busy), .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    logic [31:0] p;
    logic [3:0]  idx;
    int          dw;
  } exp_t;

  exp_t sbq[$];
  int   errors;
  int   checks;
  int   strobes;
  int   dones;
  int   cnt;
  int   last_dw;
  bit   active;
  bit [1:0] hist;
  int   tick_mode;  // 0 off, 1 held high, 4 every 4th clk, 2 manual
  int   tick_ph;

  task automatic push(input logic [31:0] f, input logic [31:0] p,
                      input logic [3:0] idx, input int dw);
    exp_t e;
    e.f = f; e.p = p; e.idx = idx; e.dw = dw;
    sbq.push_back(e);
  endtask

  // One clock: observe outputs on the falling edge, score hops, set next tick.
  task automatic step();
    exp_t e;
    int   meas;
    @(negedge clk);
    hist = {hist[0], sample_tick};
    if (hop_strobe === 1'b1) begin
      strobes++;
      if (active) begin
        meas = cnt - int'(hist[1]);
        checks++;
        if (meas !== last_dw) begin
          errors++;
          $display("FAIL sb_dwell: measured %0d ticks, expected %0d", meas, last_dw);
        end
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_strobe: hop_idx=%0d with empty scoreboard", hop_idx);
        active = 1'b0;
      end else begin
        e = sbq.pop_front();
        if ({nco_freq, nco_phase, hop_idx, nco_enable, nco_phase_rst} !==
            {e.f, e.p, e.idx, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL sb_entry: got f=%h p=%h idx=%0d en=%b prst=%b, expected f=%h p=%h idx=%0d en=1 prst=1",
                   nco_freq, nco_phase, hop_idx, nco_enable, nco_phase_rst, e.f, e.p, e.idx);
        end
        last_dw = e.dw;
        cnt     = 0;
        active  = 1'b1;
      end
    end else if (active) begin
      cnt += int'(hist[0]);
    end
    if (done === 1'b1) begin
      dones++;
      if (active) begin
        checks++;
        if (cnt !== last_dw) begin
          errors++;
          $display("FAIL sb_last_dwell: measured %0d ticks, expected %0d", cnt, last_dw);
        end
      end
      active = 1'b0;
    end
    case (tick_mode)
      0: sample_tick = 1'b0;
      1: sample_tick = 1'b1;
      4: begin
        sample_tick = (tick_ph % 4 == 0);
        tick_ph++;
      end
      default: ;
    endcase
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [31:0] f,
                             input logic [31:0] p, input logic [15:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_freq = f; tbl_phase = p; tbl_dwell = d;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int d0;
    d0 = dones;
    for (int i = 0; i < lim && dones == d0; i++) step();
    checks++;
    if (dones == d0) begin
      errors++;
      $display("FAIL wait_done_timeout: no done within %0d cycles", lim);
    end
  endtask

  task automatic wait_idx1(input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      step();
      seen = (hop_strobe === 1'b1) && (hop_idx === 4'd1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_idx1_timeout: entry 1 not applied within %0d cycles", lim);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({nco_freq, nco_phase, nco_enable, nco_phase_rst, hop_strobe, hop_idx, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: f=%h p=%h en=%b prst=%b hs=%b idx=%0d busy=%b done=%b err=%b, expected all 0",
               nco_freq, nco_phase, nco_enable, nco_phase_rst, hop_strobe, hop_idx, busy, done, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    int s0, d0;
    s0 = strobes; d0 = dones;
    push(32'h1000_0000, '0, 4'd0, 4);
    push(32'h2000_0000, '0, 4'd1, 2);
    push(32'h4000_0000, '0, 4'd2, 1);
    num_hops = 5'd3; loop_en = 1'b0; tick_mode = 4;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(300);
    step();
    checks++;
    if ((strobes - s0) !== 3 || (dones - d0) !== 1) begin
      errors++;
      $display("FAIL seq_counts: strobes=%0d dones=%0d, expected 3 and 1", strobes - s0, dones - d0);
    end
    checks++;
    if ({nco_enable, busy} !== 2'b00 || sbq.size() != 0) begin
      errors++;
      $display("FAIL seq_end: en=%b busy=%b pending=%0d, expected 0 0 0", nco_enable, busy, sbq.size());
    end
  endtask

  task automatic test_loop();
    int s0, d0;
    s0 = strobes; d0 = dones;
    for (int k = 0; k < 2; k++) begin
      push(32'h1000_0000, '0, 4'd0, 4);
      push(32'h2000_0000, '0, 4'd1, 2);
      push(32'h4000_0000, '0, 4'd2, 1);
    end
    num_hops = 5'd3; loop_en = 1'b1; tick_mode = 4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 300 && (strobes - s0) < 5; i++) step();
    checks++;
    if ((strobes - s0) !== 5 || dones !== d0) begin
      errors++;
      $display("FAIL loop_wrap: strobes=%0d dones=%0d, expected 5 and 0", strobes - s0, dones - d0);
    end
    loop_en = 1'b0;
    wait_done(300);
    step();
    checks++;
    if ((strobes - s0) !== 6 || (dones - d0) !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_end: strobes=%0d dones=%0d busy=%b, expected 6 1 0", strobes - s0, dones - d0, busy);
    end
  endtask

  task automatic test_err();
    logic [4:0] bad [2];
    bad[0] = 5'd0; bad[1] = 5'd17;
    tick_mode = 0;
    for (int k = 0; k < 2; k++) begin
      num_hops = bad[k];
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({err, busy} !== 2'b10) begin
        errors++;
        $display("FAIL err_pulse: nh=%0d err=%b busy=%b, expected 1 0", bad[k], err, busy);
      end
      step();
      checks++;
      if ({err, busy, nco_enable, hop_idx, nco_freq} !== {3'b000, 4'd2, 32'h4000_0000}) begin
        errors++;
        $display("FAIL err_after: nh=%0d err=%b busy=%b en=%b idx=%0d f=%h, expected 0 0 0 2 40000000",
                 bad[k], err, busy, nco_enable, hop_idx, nco_freq);
      end
    end
  endtask

  task automatic test_stop();
    int s0, d0;
    push(32'h1000_0000, '0, 4'd0, 4);
    push(32'h2000_0000, '0, 4'd1, 2);
    num_hops = 5'd3; loop_en = 1'b0; tick_mode = 4;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx1(300);
    tick_mode = 2;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    s0 = strobes; d0 = dones;
    sample_tick = 1'b1; stop = 1'b1;
    step();
    stop = 1'b0;
    tick_mode = 0;
    checks++;
    if ({busy, nco_enable, hop_strobe, done} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_state: busy=%b en=%b hs=%b done=%b, expected 0 0 0 0", busy, nco_enable, hop_strobe, done);
    end
    sbq.delete();
    active = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (strobes !== s0 || dones !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_quiet: extra strobes=%0d dones=%0d busy=%b, expected 0 0 0", strobes - s0, dones - d0, busy);
    end
  endtask

  task automatic test_rst_mid();
    push(32'h1000_0000, '0, 4'd0, 4);
    push(32'h2000_0000, '0, 4'd1, 2);
    push(32'h4000_0000, '0, 4'd2, 1);
    num_hops = 5'd3; loop_en = 1'b0; tick_mode = 4;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx1(300);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({nco_freq, nco_phase, nco_enable, nco_phase_rst, hop_strobe, hop_idx, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL rst_mid: f=%h p=%h en=%b prst=%b hs=%b idx=%0d busy=%b done=%b err=%b, expected all 0",
               nco_freq, nco_phase, nco_enable, nco_phase_rst, hop_strobe, hop_idx, busy, done, err);
    end
    sbq.delete();
    active = 1'b0;
    step();
    test_sequence();
  endtask

  task automatic test_dwell_zero();
    write_entry(4'd0, 32'h0ABC_0000, 32'h1234_5678, 16'd0);
    write_entry(4'd1, 32'h0DEF_0000, 32'h8765_4321, 16'd3);
    push(32'h0ABC_0000, 32'h1234_5678, 4'd0, 1);
    push(32'h0DEF_0000, 32'h8765_4321, 4'd1, 3);
    num_hops = 5'd2; loop_en = 1'b0; tick_mode = 1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, hop_strobe, nco_enable} !== 3'b100) begin
      errors++;
      $display("FAIL lat_start_t0: busy=%b hs=%b en=%b, expected 1 0 0", busy, hop_strobe, nco_enable);
    end
    step();
    checks++;
    if (hop_strobe !== 1'b0) begin
      errors++;
      $display("FAIL lat_start_t1: hs=%b, expected 0", hop_strobe);
    end
    step();
    checks++;
    if ({hop_strobe, nco_enable, hop_idx} !== {2'b11, 4'd0}) begin
      errors++;
      $display("FAIL lat_start_t2: hs=%b en=%b idx=%0d, expected 1 1 0", hop_strobe, nco_enable, hop_idx);
    end
    step(); step();
    checks++;
    if (hop_strobe !== 1'b0) begin
      errors++;
      $display("FAIL lat_hop_gap: hs=%b one cycle early, expected 0", hop_strobe);
    end
    step();
    checks++;
    if ({hop_strobe, hop_idx} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL lat_hop: hs=%b idx=%0d, expected 1 1", hop_strobe, hop_idx);
    end
    wait_done(50);
    tick_mode = 0;
    step();
    checks++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_end: pending=%0d busy=%b, expected 0 0", sbq.size(), busy);
    end
  endtask

  initial begin
    errors = 0; checks = 0; strobes = 0; dones = 0; cnt = 0; last_dw = 0;
    active = 1'b0; hist = '0; tick_mode = 0; tick_ph = 0;
    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_freq = '0; tbl_phase = '0;
    tbl_dwell = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_hops = '0;
    sample_tick = 1'b0;
    test_reset();
    write_entry(4'd0, 32'h1000_0000, '0, 16'd4);
    write_entry(4'd1, 32'h2000_0000, '0, 16'd2);
    write_entry(4'd2, 32'h4000_0000, '0, 16'd1);
    test_sequence();
    test_loop();
    test_err();
    test_stop();
    test_rst_mid();
    test_dwell_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
